// File: rtl/fifo_pkg.sv
// Types and helpers shared by the FIFO and its downstream word packer.
package fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  function automatic int bytes_to_word_width(input int data_width, input int bytes_per_word);
    return data_width * bytes_per_word;
  endfunction

endpackage

// File: rtl/fifo_word_packer_if.sv
// FIFO read port plus packed-word valid/ready stream seen by fifo_word_packer.
interface fifo_word_packer_if #(
  parameter int DATA_WIDTH     = fifo_pkg::DEF_DATA_WIDTH,
  parameter int BYTES_PER_WORD = 4,
  parameter int CNT_W          = 3,
  parameter int WCNT_W         = 16
);
  import fifo_pkg::*;

  localparam int WORD_W = bytes_to_word_width(DATA_WIDTH, BYTES_PER_WORD);

  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data_out;
  logic                  fifo_read_en;
  logic                  flush;
  logic [WORD_W-1:0]     word_out;
  logic [CNT_W-1:0]      word_bytes;
  logic                  word_valid;
  logic                  word_ready;
  logic [WCNT_W-1:0]     word_count;

  modport master (
    input  fifo_empty, fifo_data_out, flush, word_ready,
    output fifo_read_en, word_out, word_bytes, word_valid, word_count
  );

  modport slave (
    output fifo_empty, fifo_data_out, flush, word_ready,
    input  fifo_read_en, word_out, word_bytes, word_valid, word_count
  );

endinterface

// File: rtl/fifo_word_packer.sv
// Pops bytes from the synchronous FIFO, packs them little-endian into words
// and offers each word on a valid/ready stream; flush emits a padded partial word.
module fifo_word_packer
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int BYTES_PER_WORD = 4,
  parameter int CNT_W          = 3,
  parameter int WCNT_W         = 16
) (
  input logic                clk,
  input logic                reset,
  fifo_word_packer_if.master bus
);

  localparam logic [CNT_W:0]   FULL_OCC = (CNT_W+1)'(BYTES_PER_WORD);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BYTES_PER_WORD);

  state_t                                    state_r, state_n;
  logic [CNT_W-1:0]                          count_r, count_n;
  logic                                      inflight_r;
  logic                                      flush_pend_r, flush_pend_n;
  logic [BYTES_PER_WORD-1:0][DATA_WIDTH-1:0] lanes_r, lanes_n;
  logic [CNT_W-1:0]                          word_bytes_r, word_bytes_n;
  logic                                      word_valid_r, word_valid_n;
  logic [WCNT_W-1:0]                         word_count_r, word_count_n;
  logic [CNT_W:0]                            occupancy_s;
  logic [CNT_W-1:0]                          count_inc_s;
  logic                                      read_en_s;

  // Bytes captured plus the one possibly in flight decide whether another pop fits.
  assign occupancy_s = {1'b0, count_r} + {{CNT_W{1'b0}}, inflight_r};
  assign count_inc_s = count_r + CNT_W'(1);
  assign read_en_s   = reset && (state_r == FILL) && !bus.fifo_empty &&
                       !flush_pend_r && (occupancy_s < FULL_OCC);

  // Next-state: capture in-flight bytes, resolve flush, release accepted words.
  always_comb begin
    state_n      = state_r;
    count_n      = count_r;
    flush_pend_n = flush_pend_r;
    lanes_n      = lanes_r;
    word_bytes_n = word_bytes_r;
    word_valid_n = word_valid_r;
    word_count_n = word_count_r;
    case (state_r)
      FILL: begin
        if (bus.flush && (occupancy_s != '0)) begin
          flush_pend_n = 1'b1;
        end else begin
          flush_pend_n = flush_pend_r;
        end
        if (inflight_r) begin
          for (int i = 0; i < BYTES_PER_WORD; i++) begin
            if (count_r == CNT_W'(i)) begin
              lanes_n[i] = bus.fifo_data_out;
            end else begin
              lanes_n[i] = lanes_r[i];
            end
          end
          count_n = count_inc_s;
          // A capture that completes the word supersedes any pending flush.
          if (count_inc_s == FULL_CNT) begin
            state_n      = HOLD;
            word_valid_n = 1'b1;
            word_bytes_n = FULL_CNT;
            flush_pend_n = 1'b0;
          end else begin
            state_n = FILL;
          end
        end else if (flush_pend_r) begin
          flush_pend_n = 1'b0;
          if (count_r != '0) begin
            state_n      = HOLD;
            word_valid_n = 1'b1;
            word_bytes_n = count_r;
          end else begin
            state_n = FILL;
          end
        end else begin
          state_n = FILL;
        end
      end
      HOLD: begin
        if (word_valid_r && bus.word_ready) begin
          state_n      = FILL;
          word_valid_n = 1'b0;
          lanes_n      = '0;
          count_n      = '0;
          word_count_n = word_count_r + WCNT_W'(1);
        end else begin
          state_n = HOLD;
        end
      end
      default: begin
        state_n = FILL;
      end
    endcase
  end

  // State and output registers; reset discards any partial word and in-flight byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= FILL;
      count_r      <= '0;
      inflight_r   <= 1'b0;
      flush_pend_r <= 1'b0;
      lanes_r      <= '0;
      word_bytes_r <= '0;
      word_valid_r <= 1'b0;
      word_count_r <= '0;
    end else begin
      state_r      <= state_n;
      count_r      <= count_n;
      inflight_r   <= read_en_s;
      flush_pend_r <= flush_pend_n;
      lanes_r      <= lanes_n;
      word_bytes_r <= word_bytes_n;
      word_valid_r <= word_valid_n;
      word_count_r <= word_count_n;
    end
  end

  assign bus.fifo_read_en = read_en_s;
  assign bus.word_out     = lanes_r;
  assign bus.word_bytes   = word_bytes_r;
  assign bus.word_valid   = word_valid_r;
  assign bus.word_count   = word_count_r;

endmodule
